// File: rtl/instr_dispatch_pkg.sv
// Shared types and helpers for the round-robin instruction dispatcher.
package instr_dispatch_pkg;

  localparam int unsigned MAX_CORES = 8;
  localparam int unsigned MAX_PTR_W = 3;

  typedef struct packed {
    logic                 found;
    logic [MAX_PTR_W-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned ptr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of mask, scanning upward from start and wrapping at n.
  function automatic rr_pick_t rr_find_first(input logic [MAX_CORES-1:0] mask,
                                             input logic [MAX_PTR_W-1:0] start,
                                             input int unsigned          n);
    rr_pick_t    pick;
    int unsigned idx;
    pick = '0;
    for (int unsigned k = 0; k < MAX_CORES; k++) begin
      idx = 32'(start) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && idx < MAX_CORES && !pick.found) begin
        if (mask[MAX_PTR_W'(idx)]) begin
          pick.found = 1'b1;
          pick.idx   = MAX_PTR_W'(idx);
        end
      end
    end
    return pick;
  endfunction

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/dispatch_lane_slot.sv
// One-entry output slot: holds an instruction and its tag until the lane accepts it.
module dispatch_lane_slot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEQ_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [SEQ_W-1:0]  load_seq,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SEQ_W-1:0]  out_seq
);

  // A load wins over a drain so the slot can be emptied and refilled in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_seq   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_seq   <= load_seq;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_dispatch_rr.sv
// Round-robin distributor steering one tagged instruction per cycle into N lane slots.
module instr_dispatch_rr
  import instr_dispatch_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N_CORES   = 2,
  parameter int unsigned SEQ_W     = 8,
  parameter int unsigned STRICT_RR = 1,
  localparam int unsigned PTR_W    = ptr_w(N_CORES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic [N_CORES-1:0]         lane_en,
  output logic [N_CORES-1:0]         out_valid,
  input  logic [N_CORES-1:0]         out_ready,
  output logic [N_CORES*DATA_W-1:0]  out_data,
  output logic [N_CORES*SEQ_W-1:0]   out_seq,
  output logic [PTR_W-1:0]           rr_ptr
);

  logic [N_CORES-1:0] avail;
  logic [N_CORES-1:0] sel_mask;
  logic [N_CORES-1:0] lane_load;
  rr_pick_t           pick;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [SEQ_W-1:0]   seq_q;
  logic               accept;

  // Strict mode waits on the pointed enabled lane; relaxed mode takes any free lane.
  always_comb begin
    avail    = lane_en & (~out_valid | out_ready);
    sel_mask = (STRICT_RR != 0) ? lane_en : avail;
    pick     = rr_find_first(MAX_CORES'(sel_mask), MAX_PTR_W'(rr_ptr), N_CORES);
    sel      = PTR_W'(pick.idx);
    in_ready = ~reset & pick.found & avail[sel];
    accept   = in_valid & in_ready;
    ptr_nxt  = (32'(sel) == N_CORES - 1) ? '0 : sel + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      seq_q  <= '0;
    end else if (accept) begin
      rr_ptr <= ptr_nxt;
      seq_q  <= seq_q + SEQ_W'(1);
    end
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_lane
    assign lane_load[g] = accept & (32'(sel) == g);

    dispatch_lane_slot #(
      .DATA_W (DATA_W),
      .SEQ_W  (SEQ_W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (lane_load[g]),
      .load_data (in_data),
      .load_seq  (seq_q),
      .out_ready (out_ready[g]),
      .out_valid (out_valid[g]),
      .out_data  (out_data[lane_lo(g, DATA_W) +: DATA_W]),
      .out_seq   (out_seq[lane_lo(g, SEQ_W) +: SEQ_W])
    );
  end

endmodule
